ifmap_mc_rx: RTL and testbench

IFMAP_MC_RX -- requirements
Module: ifmap_mc_rx

---
 rtl/glb_bus_pkg.sv | 20 ++
 rtl/mc_rx_fifo.sv | 59 +++++
 rtl/ifmap_mc_rx.sv | 108 ++++++++++
 tb/tb_ifmap_mc_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glb_bus_pkg
//  Description : Shared definitions for the global ifmap multicast bus:
//                receiver FSM state encoding and the reserved idle tag.
//  Revision    : 1.0 - initial release
// ============================================================================
package glb_bus_pkg;

    // Receiver configuration state
    typedef enum logic [0:0] {
        ST_UNCFG = 1'b0,
        ST_ARMED = 1'b1
    } rx_state_e;

    // Tag value carried by the bus when no receiver is addressed
    localparam int unsigned BUS_IDLE_TAG = 0;

endpackage : glb_bus_pkg
`default_nettype wire

// File: rtl/mc_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mc_rx_fifo
//  Description : Synchronous receive FIFO for the multicast receiver.
//                Pointers carry one extra wrap bit so full/empty are
//                distinguished without a separate occupancy counter.
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_rx_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  bus_clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Pointer advance; reset empties the FIFO regardless of stored data
    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage array, no reset needed since empty hides stale entries
    always_ff @(posedge bus_clk) begin
        if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
    end

endmodule : mc_rx_fifo
`default_nettype wire

// File: rtl/ifmap_mc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ifmap_mc_rx
//  Description : Ifmap multicast receiver. Captures bus beats whose X_ID tag
//                equals the locally configured tag into a small FIFO feeding
//                the PE stream; all other beats are acknowledged and dropped.
//                Optional macro MC_RX_STALL_CNT_EN adds a saturating counter
//                of cycles in which a matching beat was back-pressured.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifmap_mc_rx
    import glb_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  bus_clk,
    input  logic                  rstn,
    input  logic                  cfg_we,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    input  logic                  bus_valid,
    input  logic [ID_WIDTH-1:0]   bus_x_id,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_ready,
    output logic                  pe_valid,
    output logic [DATA_WIDTH-1:0] pe_data,
    input  logic                  pe_ready,
`ifdef MC_RX_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  armed
);

    localparam logic [ID_WIDTH-1:0] IDLE_TAG = ID_WIDTH'(BUS_IDLE_TAG);

    rx_state_e           state_q;
    logic [ID_WIDTH-1:0] own_tag_q;
    logic                armed_q;

    logic match;
    logic fifo_full;
    logic fifo_empty;

    // A beat coinciding with cfg_we is judged against the tag still in own_tag_q
    assign match     = (state_q == ST_ARMED) && bus_valid &&
                       (bus_x_id == own_tag_q) && (bus_x_id != IDLE_TAG);
    assign bus_ready = !(match && fifo_full);
    assign pe_valid  = !fifo_empty;
    assign armed     = armed_q;

    // Configuration FSM: a zero tag disarms, any other tag arms or re-tags
    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_UNCFG;
            own_tag_q <= '0;
            armed_q   <= 1'b0;
        end else if (cfg_we) begin
            own_tag_q <= cfg_id;
            if (cfg_id == IDLE_TAG) begin
                state_q <= ST_UNCFG;
                armed_q <= 1'b0;
            end else begin
                state_q <= ST_ARMED;
                armed_q <= 1'b1;
            end
        end
    end

    mc_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .bus_clk (bus_clk),
        .rstn    (rstn),
        .push_i  (match && bus_ready),
        .wdata_i (bus_data),
        .pop_i   (pe_valid && pe_ready),
        .rdata_o (pe_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef MC_RX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Reconfiguration restarts the count; otherwise count back-pressured beats
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cfg_we) begin
            stall_cnt_d = '0;
        end else if (match && !bus_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : ifmap_mc_rx
`default_nettype wire

// File: tb/tb_ifmap_mc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifmap_mc_rx
//  Description : Self-checking bench for ifmap_mc_rx: directed vector table,
//                asynchronous reset sequence, and randomized traffic against
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifmap_mc_rx;

    localparam int DW    = 16;
    localparam int IW    = 4;
    localparam int DEPTH = 4;

    logic          bus_clk = 1'b0;
    logic          rstn;
    logic          cfg_we;
    logic [IW-1:0] cfg_id;
    logic          bus_valid;
    logic [IW-1:0] bus_x_id;
    logic [DW-1:0] bus_data;
    logic          bus_ready;
    logic          pe_valid;
    logic [DW-1:0] pe_data;
    logic          pe_ready;
    logic          armed;
`ifdef MC_RX_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 bus_clk = ~bus_clk;

    ifmap_mc_rx #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .bus_clk   (bus_clk),
        .rstn      (rstn),
        .cfg_we    (cfg_we),
        .cfg_id    (cfg_id),
        .bus_valid (bus_valid),
        .bus_x_id  (bus_x_id),
        .bus_data  (bus_data),
        .bus_ready (bus_ready),
        .pe_valid  (pe_valid),
        .pe_data   (pe_data),
        .pe_ready  (pe_ready),
`ifdef MC_RX_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .armed     (armed)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [IW-1:0] id;
        logic          bv;
        logic [IW-1:0] tag;
        logic [DW-1:0] data;
        logic          pr;
        logic          e_ready;
        logic          e_pv;
        logic [DW-1:0] e_pd;
        logic          e_armed;
        logic          chk_stall;
        logic [15:0]   e_stall;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [IW-1:0] id, input logic bv,
                         input logic [IW-1:0] tag, input logic [DW-1:0] data, input logic pr);
        cfg_we    = we;
        cfg_id    = id;
        bus_valid = bv;
        bus_x_id  = tag;
        bus_data  = data;
        pe_ready  = pr;
    endtask

    function automatic vec_t mk(logic we, logic [IW-1:0] id, logic bv, logic [IW-1:0] tag,
                                logic [DW-1:0] data, logic pr, logic er, logic epv,
                                logic [DW-1:0] epd, logic ea, logic cs, logic [15:0] es);
        vec_t v;
        v.we = we; v.id = id; v.bv = bv; v.tag = tag; v.data = data; v.pr = pr;
        v.e_ready = er; v.e_pv = epv; v.e_pd = epd; v.e_armed = ea;
        v.chk_stall = cs; v.e_stall = es;
        return v;
    endfunction

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] mq[$];
        int            beats;
        int            cycles;
        int            pushed;
        int            popped;
        logic          cur_bv;
        logic [IW-1:0] cur_tag;
        logic [DW-1:0] cur_data;
        logic          pr;
        logic          m;
        logic          e_ready;
        logic          e_pv;

        // ------------------------------------------------------------------
        // Directed table: each row is one cycle, expectations hand-derived
        //     we id  bv tag data     pr  rdy pv pd       arm cs stall
        // ------------------------------------------------------------------
        // Basic filtering: tags 3,5,3 with own tag 3
        vt.push_back(mk(1, 3, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 1, 16'd0));
        vt.push_back(mk(0, 0, 1, 3, 16'h0011, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 5, 16'h0022, 1, 1, 1, 16'h0011, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 3, 16'h0033, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0033, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        // Idle tag never matches; UNCFG captures nothing
        vt.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 0, 16'h0044, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 1, 16'h0055, 1, 1, 0, 16'h0000, 0, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 0, 16'h0066, 1, 1, 0, 16'h0000, 0, 0, 16'd0));
        // Two words held across disarm, then drained
        vt.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0A01, 0, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0A02, 0, 1, 1, 16'h0A01, 1, 0, 16'd0));
        vt.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h0A01, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h0A01, 0, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0A01, 0, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0A02, 0, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'd0));
        // Re-tag 4->6 in the same cycle as a tag-4 beat: beat uses old tag
        vt.push_back(mk(1, 4, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'd0));
        vt.push_back(mk(1, 6, 1, 4, 16'h0B04, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 4, 16'h0B05, 1, 1, 1, 16'h0B04, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'd0));
        // Back-pressure: tag 2, pe_ready low, six beats held until accepted
        vt.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0201, 0, 1, 0, 16'h0000, 1, 1, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0202, 0, 1, 1, 16'h0201, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0203, 0, 1, 1, 16'h0201, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0204, 0, 1, 1, 16'h0201, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0205, 0, 0, 1, 16'h0201, 1, 1, 16'd0));
        vt.push_back(mk(0, 0, 1, 2, 16'h0205, 0, 0, 1, 16'h0201, 1, 1, 16'd1));
        vt.push_back(mk(0, 0, 1, 2, 16'h0205, 1, 0, 1, 16'h0201, 1, 1, 16'd2));
        vt.push_back(mk(0, 0, 1, 2, 16'h0205, 1, 1, 1, 16'h0202, 1, 1, 16'd3));
        vt.push_back(mk(0, 0, 1, 2, 16'h0206, 1, 1, 1, 16'h0203, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0204, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0205, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0206, 1, 0, 16'd0));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 1, 16'd3));

        // ------------------------------------------------------------------
        // Power-on reset
        // ------------------------------------------------------------------
        rstn = 1'b0;
        drive(0, 0, 0, 0, 16'h0000, 0);
        repeat (3) @(posedge bus_clk);
        #1 rstn = 1'b1;
        @(negedge bus_clk);
        chk("reset_pe_valid", 32'(pe_valid), 32'd0);
        chk("reset_armed", 32'(armed), 32'd0);
        chk("reset_bus_ready", 32'(bus_ready), 32'd1);

        // ------------------------------------------------------------------
        // Apply directed table
        // ------------------------------------------------------------------
        foreach (vt[i]) begin
            @(posedge bus_clk);
            #1 drive(vt[i].we, vt[i].id, vt[i].bv, vt[i].tag, vt[i].data, vt[i].pr);
            @(negedge bus_clk);
            chk($sformatf("vec%0d_bus_ready", i), 32'(bus_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d_pe_valid", i), 32'(pe_valid), 32'(vt[i].e_pv));
            chk($sformatf("vec%0d_armed", i), 32'(armed), 32'(vt[i].e_armed));
            if (vt[i].e_pv)
                chk($sformatf("vec%0d_pe_data", i), 32'(pe_data), 32'(vt[i].e_pd));
`ifdef MC_RX_STALL_CNT_EN
            if (vt[i].chk_stall)
                chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vt[i].e_stall));
`endif
        end

        // ------------------------------------------------------------------
        // Mid-stream asynchronous reset with three words buffered
        // ------------------------------------------------------------------
        @(posedge bus_clk); #1 drive(1, 7, 0, 0, 16'h0000, 0);
        @(posedge bus_clk); #1 drive(0, 0, 1, 7, 16'h0701, 0);
        @(posedge bus_clk); #1 drive(0, 0, 1, 7, 16'h0702, 0);
        @(posedge bus_clk); #1 drive(0, 0, 1, 7, 16'h0703, 0);
        @(posedge bus_clk); #1 drive(0, 0, 0, 0, 16'h0000, 0);
        @(negedge bus_clk);
        chk("prerst_pe_valid", 32'(pe_valid), 32'd1);
        chk("prerst_pe_data", 32'(pe_data), 32'h0701);
        @(posedge bus_clk);
        #1 rstn = 1'b0;
        #1;
        chk("asyncrst_pe_valid", 32'(pe_valid), 32'd0);
        chk("asyncrst_armed", 32'(armed), 32'd0);
        chk("asyncrst_bus_ready", 32'(bus_ready), 32'd1);
`ifdef MC_RX_STALL_CNT_EN
        chk("asyncrst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge bus_clk);
        #1 rstn = 1'b1;
        drive(0, 0, 1, 7, 16'h07AA, 1);
        @(negedge bus_clk);
        chk("postrst_bus_ready", 32'(bus_ready), 32'd1);
        chk("postrst_armed", 32'(armed), 32'd0);
        @(posedge bus_clk); #1 drive(1, 7, 0, 0, 16'h0000, 1);
        @(negedge bus_clk);
        chk("postrst_no_capture", 32'(pe_valid), 32'd0);
        @(posedge bus_clk); #1 drive(0, 0, 1, 7, 16'h07BB, 1);
        @(posedge bus_clk); #1 drive(0, 0, 0, 0, 16'h0000, 1);
        @(negedge bus_clk);
        chk("reload_pe_valid", 32'(pe_valid), 32'd1);
        chk("reload_pe_data", 32'(pe_data), 32'h07BB);
        @(posedge bus_clk); #1 drive(1, 6, 0, 0, 16'h0000, 1);
        @(negedge bus_clk);
        chk("reload_drained", 32'(pe_valid), 32'd0);

        // ------------------------------------------------------------------
        // Randomized traffic, own tag 6, reference model is a plain queue
        // ------------------------------------------------------------------
        beats  = 0;
        cycles = 0;
        pushed = 0;
        popped = 0;
        cur_bv = 1'b0;
        cur_tag = '0;
        cur_data = '0;
        while ((beats < 1000 || mq.size() != 0) && cycles < 20000) begin
            if (!cur_bv && beats < 1000) begin
                cur_bv   = ($urandom % 4) != 0;
                case ($urandom % 4)
                    0, 1:    cur_tag = 4'd6;
                    2:       cur_tag = 4'd0;
                    default: cur_tag = 4'($urandom_range(1, 15));
                endcase
                cur_data = 16'($urandom);
            end
            if (beats >= 1000)          pr = 1'b1;
            else if (beats < 500)       pr = ($urandom % 4) == 0;
            else                        pr = ($urandom % 4) != 0;
            @(posedge bus_clk);
            #1 drive(0, 0, cur_bv, cur_tag, cur_data, pr);
            @(negedge bus_clk);
            m       = cur_bv && (cur_tag == 4'd6);
            e_ready = !(m && mq.size() == DEPTH);
            e_pv    = mq.size() != 0;
            chk("rand_bus_ready", 32'(bus_ready), 32'(e_ready));
            chk("rand_pe_valid", 32'(pe_valid), 32'(e_pv));
            if (e_pv) chk("rand_pe_data", 32'(pe_data), 32'(mq[0]));
            if (e_pv && pr) begin
                void'(mq.pop_front());
                popped++;
            end
            if (m && e_ready) begin
                mq.push_back(cur_data);
                pushed++;
            end
            if (cur_bv && e_ready) begin
                cur_bv = 1'b0;
                beats++;
            end
            cycles++;
        end
        chk("rand_completed", 32'(cycles < 20000), 32'd1);
        chk("rand_all_delivered", 32'(popped), 32'(pushed));
        @(posedge bus_clk); #1 drive(0, 0, 0, 0, 16'h0000, 1);
        @(negedge bus_clk);
        chk("rand_final_empty", 32'(pe_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifmap_mc_rx
`default_nettype wire
